// File: rtl/bus_read_arbiter.sv
// Grant controller for the three-master read bus: holds one grant per full read transaction and flags burst-length mismatches.
// Optional round-robin arbitration is compiled in with BUS_ARB_ROUND_ROBIN_EN; default is fixed priority m0 > m1 > m2.
module bus_read_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_arvalid,
    input  logic       m1_arvalid,
    input  logic       m2_arvalid,
    input  logic       arvalid,
    input  logic       arready,
    input  logic [3:0] arlen,
    input  logic       rvalid,
    input  logic       rready,
    input  logic       rlast,
    output logic       m0_grnt,
    output logic       m1_grnt,
    output logic       m2_grnt,
    output logic       busy,
    output logic       len_err
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t     state, state_d;
    logic [2:0] grant, grant_d;
    logic [2:0] req;
    logic [2:0] winner;
    logic [3:0] len_q, len_d;
    logic [3:0] beat_cnt, beat_d;
    logic       err_d;

    assign req = {m2_arvalid, m1_arvalid, m0_arvalid};

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr, ptr_d;

    // Search starts one past the last granted master.
    always_comb begin
        winner = '0;
        case (ptr)
            2'd0: begin
                if (req[1])      winner = 3'b010;
                else if (req[2]) winner = 3'b100;
                else if (req[0]) winner = 3'b001;
            end
            2'd1: begin
                if (req[2])      winner = 3'b100;
                else if (req[0]) winner = 3'b001;
                else if (req[1]) winner = 3'b010;
            end
            default: begin
                if (req[0])      winner = 3'b001;
                else if (req[1]) winner = 3'b010;
                else if (req[2]) winner = 3'b100;
            end
        endcase
    end

    // A grant is issued exactly when ADDR is entered from another state.
    always_comb begin
        ptr_d = ptr;
        if (state_d == ADDR && state != ADDR) begin
            if (grant_d[1])      ptr_d = 2'd1;
            else if (grant_d[2]) ptr_d = 2'd2;
            else                 ptr_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr <= 2'd2;
        else     ptr <= ptr_d;
    end
`else
    always_comb begin
        winner = '0;
        if (req[0])      winner = 3'b001;
        else if (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
    end
`endif

    always_comb begin
        state_d = state;
        grant_d = grant;
        len_d   = len_q;
        beat_d  = beat_cnt;
        err_d   = len_err;
        case (state)
            IDLE: begin
                if (|winner) begin
                    grant_d = winner;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (arvalid && arready) begin
                    len_d   = arlen;
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (rvalid && rready) begin
                    beat_d = beat_cnt + 4'd1;
                    if (rlast) begin
                        if (beat_cnt != len_q) err_d = 1'b1;
                        // Re-arbitrate on the completing beat so back-to-back grants need no idle cycle.
                        if (|winner) begin
                            grant_d = winner;
                            state_d = ADDR;
                        end else begin
                            grant_d = '0;
                            state_d = IDLE;
                        end
                    end else if (beat_cnt == len_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            len_q    <= len_d;
            beat_cnt <= beat_d;
            len_err  <= err_d;
        end
    end

    assign m0_grnt = grant[0];
    assign m1_grnt = grant[1];
    assign m2_grnt = grant[2];
    assign busy    = |grant;

endmodule

// File: tb/tb_bus_read_arbiter.sv
// Scoreboard bench for bus_read_arbiter: the driver queues hand-computed expected grants/len_err per cycle, the monitor pops and compares.
module tb_bus_read_arbiter;

    logic       clk;
    logic       rst;
    logic       m0_arvalid, m1_arvalid, m2_arvalid;
    logic       arvalid, arready;
    logic [3:0] arlen;
    logic       rvalid, rready, rlast;
    logic       m0_grnt, m1_grnt, m2_grnt;
    logic       busy;
    logic       len_err;

    logic [3:0] exp_q[$];
    logic       done;
    int         checks;
    int         errors;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam logic [2:0] G1 = 3'b010;
    localparam logic [2:0] G2 = 3'b100;
`else
    localparam logic [2:0] G1 = 3'b001;
    localparam logic [2:0] G2 = 3'b001;
`endif

    bus_read_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .m0_arvalid (m0_arvalid),
        .m1_arvalid (m1_arvalid),
        .m2_arvalid (m2_arvalid),
        .arvalid    (arvalid),
        .arready    (arready),
        .arlen      (arlen),
        .rvalid     (rvalid),
        .rready     (rready),
        .rlast      (rlast),
        .m0_grnt    (m0_grnt),
        .m1_grnt    (m1_grnt),
        .m2_grnt    (m2_grnt),
        .busy       (busy),
        .len_err    (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    // One bus cycle: inputs driven at negedge, expected state after the next posedge queued.
    task automatic cyc(input logic r, input logic [2:0] req, input logic av, input logic ar,
                       input logic [3:0] len, input logic rv, input logic rr, input logic rl,
                       input logic [2:0] eg, input logic ee);
        @(negedge clk);
        rst        = r;
        m0_arvalid = req[0];
        m1_arvalid = req[1];
        m2_arvalid = req[2];
        arvalid    = av;
        arready    = ar;
        arlen      = len;
        rvalid     = rv;
        rready     = rr;
        rlast      = rl;
        exp_q.push_back({eg, ee});
    endtask

    initial begin
        done = 1'b0;
        rst = 1'b1;
        {m0_arvalid, m1_arvalid, m2_arvalid, arvalid, arready, rvalid, rready, rlast} = '0;
        arlen = '0;

        // reset state
        cyc(1, 3'b000, 0, 0, 4'd0, 0, 0, 0, 3'b000, 0);
        cyc(1, 3'b000, 0, 0, 4'd0, 0, 0, 0, 3'b000, 0);

        // single request m1, arready after 2 cycles, arlen=3, 4 beats; rvalid in ADDR ignored
        cyc(0, 3'b010, 0, 0, 4'd0, 0, 0, 0, 3'b010, 0);
        cyc(0, 3'b010, 1, 0, 4'd0, 1, 1, 1, 3'b010, 0);
        cyc(0, 3'b010, 1, 0, 4'd0, 0, 0, 0, 3'b010, 0);
        cyc(0, 3'b010, 1, 1, 4'd3, 0, 0, 0, 3'b010, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 0, 3'b010, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 0, 3'b010, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 0, 3'b010, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 1, 3'b000, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 0, 0, 0, 3'b000, 0);

        // contention, arlen=0, back-to-back without idle cycle
        cyc(1, 3'b000, 0, 0, 4'd0, 0, 0, 0, 3'b000, 0);
        cyc(0, 3'b111, 0, 0, 4'd0, 0, 0, 0, 3'b001, 0);
        cyc(0, 3'b111, 1, 1, 4'd0, 0, 0, 0, 3'b001, 0);
        cyc(0, 3'b111, 0, 0, 4'd0, 1, 1, 1, G1,     0);
        cyc(0, 3'b111, 1, 1, 4'd0, 0, 0, 0, G1,     0);
        cyc(0, 3'b111, 0, 0, 4'd0, 1, 1, 1, G2,     0);
        cyc(0, 3'b111, 1, 1, 4'd0, 0, 0, 0, G2,     0);
        cyc(0, 3'b111, 0, 0, 4'd0, 1, 1, 1, 3'b001, 0);
        cyc(0, 3'b111, 1, 1, 4'd0, 0, 0, 0, 3'b001, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 1, 3'b000, 0);

        // length error: arlen=3, rlast on 2nd beat; sticky
        cyc(1, 3'b000, 0, 0, 4'd0, 0, 0, 0, 3'b000, 0);
        cyc(0, 3'b001, 0, 0, 4'd0, 0, 0, 0, 3'b001, 0);
        cyc(0, 3'b000, 1, 1, 4'd3, 0, 0, 0, 3'b001, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 0, 3'b001, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 1, 3'b000, 1);
        cyc(0, 3'b000, 0, 0, 4'd0, 0, 0, 0, 3'b000, 1);
        cyc(0, 3'b000, 0, 0, 4'd0, 0, 0, 0, 3'b000, 1);

        // overrun: arlen=1, 3 beats with a stall, error at 2nd beat, grant held to rlast
        cyc(1, 3'b000, 0, 0, 4'd0, 0, 0, 0, 3'b000, 0);
        cyc(0, 3'b001, 0, 0, 4'd0, 0, 0, 0, 3'b001, 0);
        cyc(0, 3'b000, 1, 1, 4'd1, 0, 0, 0, 3'b001, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 0, 3'b001, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 0, 0, 3'b001, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 0, 3'b001, 1);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 1, 3'b000, 1);

        // reset during beat 2 of 16, then a fresh m2 transaction
        cyc(0, 3'b001, 0, 0, 4'd0, 0, 0, 0, 3'b001, 1);
        cyc(0, 3'b000, 1, 1, 4'd15, 0, 0, 0, 3'b001, 1);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 0, 3'b001, 1);
        cyc(1, 3'b000, 0, 0, 4'd0, 1, 1, 0, 3'b000, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 0, 0, 0, 3'b000, 0);
        cyc(0, 3'b100, 0, 0, 4'd0, 0, 0, 0, 3'b100, 0);
        cyc(0, 3'b000, 1, 1, 4'd0, 0, 0, 0, 3'b100, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 1, 3'b000, 0);

        // m2 withdraws before handshake while m0 requests; grant stays with m2
        cyc(0, 3'b100, 0, 0, 4'd0, 0, 0, 0, 3'b100, 0);
        cyc(0, 3'b001, 0, 0, 4'd0, 0, 0, 0, 3'b100, 0);
        cyc(0, 3'b001, 0, 0, 4'd0, 0, 0, 0, 3'b100, 0);
        cyc(0, 3'b001, 1, 1, 4'd0, 0, 0, 0, 3'b100, 0);
        cyc(0, 3'b001, 0, 0, 4'd0, 1, 1, 1, 3'b001, 0);
        cyc(0, 3'b000, 1, 1, 4'd0, 0, 0, 0, 3'b001, 0);
        cyc(0, 3'b000, 0, 0, 4'd0, 1, 1, 1, 3'b000, 0);

        @(negedge clk);
        {m0_arvalid, m1_arvalid, m2_arvalid, arvalid, arready, rvalid, rready, rlast} = '0;
        repeat (3) @(negedge clk);
        done = 1'b1;
    end

    initial begin
        logic [3:0] e;
        logic [2:0] g;
        checks = 0;
        errors = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {m2_grnt, m1_grnt, m0_grnt};
                checks++;
                if (g !== e[3:1]) begin
                    errors++;
                    $display("FAIL grant t=%0t: got %b required %b", $time, g, e[3:1]);
                end
                checks++;
                if (busy !== |e[3:1]) begin
                    errors++;
                    $display("FAIL busy t=%0t: got %b required %b", $time, busy, |e[3:1]);
                end
                checks++;
                if (len_err !== e[0]) begin
                    errors++;
                    $display("FAIL len_err t=%0t: got %b required %b", $time, len_err, e[0]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
